// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus: decodes each granted
// address to data memory or the IO window and sequences the access to an ack.
module data_bus_arbiter #(
    parameter logic [31:0] DATA_LOW  = 32'h1001_0000,
    parameter logic [31:0] DATA_HIGH = 32'h1001_FFFF,
    parameter logic [31:0] IO_LOW    = 32'hFFFF_0000,
    parameter logic [31:0] IO_HIGH   = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    input  logic [31:0] dm_rdata,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        io_we,
    output logic        io_re,
    input  logic [31:0] io_rdata,
    input  logic        io_ready
);

    typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_t;

    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [31:0] DATA_SPAN   = DATA_HIGH - DATA_LOW;
    localparam logic [31:0] IO_SPAN     = IO_HIGH - IO_LOW;

    state_t      r_state, w_state_nxt;
    logic        r_gnt, w_gnt_nxt;
    logic        r_last, w_last_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_err, w_err_nxt;
    logic        r_rd_mem, w_rd_mem_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;

    logic        r_dm_we, w_dm_we_nxt;
    logic [31:0] r_dm_addr, w_dm_addr_nxt;
    logic [31:0] r_dm_wdata, w_dm_wdata_nxt;
    logic        r_io_we, w_io_we_nxt;
    logic        r_io_re, w_io_re_nxt;
    logic [31:0] r_io_addr, w_io_addr_nxt;
    logic [31:0] r_io_wdata, w_io_wdata_nxt;

    logic        w_arb_gnt, w_sel_we, w_in_data, w_in_io;
    logic [31:0] w_sel_addr, w_sel_wdata, w_resp_rdata;

    // On a tie the master that did not win last time is granted.
    assign w_arb_gnt   = (m0_req && m1_req) ? ~r_last : m1_req;
    assign w_sel_we    = w_arb_gnt ? m1_we    : m0_we;
    assign w_sel_addr  = w_arb_gnt ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_arb_gnt ? m1_wdata : m0_wdata;

    // Offset-from-base compare: addresses below the base wrap to huge offsets.
    assign w_in_data = (w_sel_addr - DATA_LOW) <= DATA_SPAN;
    assign w_in_io   = (w_sel_addr - IO_LOW)   <= IO_SPAN;
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_last_nxt   = r_last;
        w_we_nxt     = r_we;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        w_rd_mem_nxt = r_rd_mem;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_gnt_nxt    = w_arb_gnt;
                    w_we_nxt     = w_sel_we;
                    w_addr_nxt   = w_sel_addr;
                    w_wdata_nxt  = w_sel_wdata;
                    w_rdata_nxt  = '0;
                    w_err_nxt    = 1'b0;
                    w_rd_mem_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    if (w_in_data) begin
                        w_state_nxt  = MEM;
                        w_rd_mem_nxt = ~w_sel_we;
                    end else if (w_in_io) begin
                        w_state_nxt = IO;
                    end else begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            MEM: w_state_nxt = RESP;
            IO: begin
                w_cnt_nxt = w_cnt_inc;
                if (io_ready) begin
                    w_state_nxt = RESP;
                    w_rdata_nxt = r_we ? '0 : io_rdata;
                end else if (w_cnt_inc == TIMEOUT_CNT) begin
                    w_state_nxt = RESP;
                    w_err_nxt   = 1'b1;
                end
            end
            RESP: begin
                w_last_nxt  = r_gnt;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Target-side outputs are registered from the next state.
        w_dm_we_nxt    = (w_state_nxt == MEM) && w_we_nxt;
        w_dm_addr_nxt  = (w_state_nxt == MEM) ? w_addr_nxt  : '0;
        w_dm_wdata_nxt = (w_state_nxt == MEM) ? w_wdata_nxt : '0;
        w_io_we_nxt    = (w_state_nxt == IO) && w_we_nxt;
        w_io_re_nxt    = (w_state_nxt == IO) && !w_we_nxt;
        w_io_addr_nxt  = (w_state_nxt == IO) ? w_addr_nxt  : '0;
        w_io_wdata_nxt = (w_state_nxt == IO) ? w_wdata_nxt : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= 1'b0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_rd_mem   <= 1'b0;
            r_cnt      <= '0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_io_we    <= 1'b0;
            r_io_re    <= 1'b0;
            r_io_addr  <= '0;
            r_io_wdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last     <= w_last_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_err_nxt;
            r_rd_mem   <= w_rd_mem_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dm_we    <= w_dm_we_nxt;
            r_dm_addr  <= w_dm_addr_nxt;
            r_dm_wdata <= w_dm_wdata_nxt;
            r_io_we    <= w_io_we_nxt;
            r_io_re    <= w_io_re_nxt;
            r_io_addr  <= w_io_addr_nxt;
            r_io_wdata <= w_io_wdata_nxt;
        end
    end

    // Memory read data arrives one cycle after MEM, i.e. during RESP.
    assign w_resp_rdata = r_rd_mem ? dm_rdata : r_rdata;

    assign m0_ack   = (r_state == RESP) && !r_gnt;
    assign m1_ack   = (r_state == RESP) && r_gnt;
    assign m0_err   = m0_ack && r_err;
    assign m1_err   = m1_ack && r_err;
    assign m0_rdata = m0_ack ? w_resp_rdata : '0;
    assign m1_rdata = m1_ack ? w_resp_rdata : '0;

    assign dm_we    = r_dm_we;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
    assign io_we    = r_io_we;
    assign io_re    = r_io_re;
    assign io_addr  = r_io_addr;
    assign io_wdata = r_io_wdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_data_bus_arbiter;

    typedef struct {
        bit          m;
        int          cyc;
        logic [31:0] rdata;
        bit          err;
        int          n_dm;
        int          n_iow;
        int          n_ior;
        logic [31:0] saddr;
        logic [31:0] swdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_we;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_we, io_re, io_ready;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];

    int          io_lat = 0;
    logic [31:0] io_rdata_val = '0;
    int          io_seen = 0;
    logic [31:0] mem [16];

    int          mon_dm = 0, mon_iow = 0, mon_ior = 0;
    logic [31:0] mon_saddr = '0, mon_swdata = '0;

    data_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
        .io_rdata(io_rdata), .io_ready(io_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous data memory, one-cycle read latency.
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[5:2]] <= dm_wdata;
        dm_rdata <= mem[dm_addr[5:2]];
    end

    // Peripheral answers in its io_lat-th strobe cycle; io_lat = 0 never answers.
    always @(posedge clk) io_seen <= (io_we || io_re) ? io_seen + 1 : 0;
    assign io_ready = (io_we || io_re) && (io_lat != 0) && (io_seen == io_lat - 1);
    assign io_rdata = io_ready ? io_rdata_val : 32'hFFFF_FFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_dm = 0; mon_iow = 0; mon_ior = 0;
        end else begin
            if (dm_we) begin
                mon_dm++; mon_saddr = dm_addr; mon_swdata = dm_wdata;
            end
            if (io_we || io_re) begin
                if (io_we) mon_iow++;
                if (io_re) mon_ior++;
                mon_saddr = io_addr; mon_swdata = io_wdata;
            end
            if (m0_ack && m1_ack) check("dual_ack", 32'd1, 32'd0);
            if (m0_ack || m1_ack) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("ack_master", {31'd0, m1_ack}, {31'd0, e.m});
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                    check("err", {31'd0, e.m ? m1_err : m0_err}, {31'd0, e.err});
                    check("dm_we_cycles", 32'(mon_dm), 32'(e.n_dm));
                    check("io_we_cycles", 32'(mon_iow), 32'(e.n_iow));
                    check("io_re_cycles", 32'(mon_ior), 32'(e.n_ior));
                    if (e.n_dm + e.n_iow + e.n_ior > 0) begin
                        check("strobe_addr", mon_saddr, e.saddr);
                        check("strobe_wdata", mon_swdata, e.swdata);
                    end
                end
                mon_dm = 0; mon_iow = 0; mon_ior = 0;
            end else begin
                check("quiet_resp", m0_rdata | m1_rdata | {30'd0, m0_err, m1_err}, 32'd0);
            end
        end
    end

    task automatic issue(input bit m, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ofs, input logic [31:0] rdata,
                         input bit err, input int ndm, input int niow, input int nior);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        e.m = m; e.cyc = cyc + ofs; e.rdata = rdata; e.err = err;
        e.n_dm = ndm; e.n_iow = niow; e.n_ior = nior; e.saddr = addr; e.swdata = wdata;
        sb_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            got = m ? m1_ack : m0_ack;
        end
        check("ack_seen", {31'd0, got}, 32'd1);
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic push_exp(input bit m, input int c, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.m = m; e.cyc = c; e.rdata = '0; e.err = 1'b0;
        e.n_dm = 1; e.n_iow = 0; e.n_ior = 0; e.saddr = a; e.swdata = d;
        sb_q.push_back(e);
    endtask

    initial begin
        int t;
        int n_ack;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        check("rst_strobes", {29'd0, dm_we, io_we, io_re}, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_io_addr", io_addr, 32'd0);
        rst = 1'b0;

        issue(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, 0, 0);
        issue(1'b0, 1'b0, 32'h1001_0004, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);

        io_lat = 3; io_rdata_val = 32'h0000_005A;
        issue(1'b1, 1'b0, 32'hFFFF_0010, 32'h0, 4, 32'h0000_005A, 1'b0, 0, 0, 3);
        io_lat = 0;
        issue(1'b0, 1'b1, 32'hFFFF_0040, 32'hCAFE_0001, 17, 32'h0, 1'b1, 0, 16, 0);
        issue(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0, 1'b1, 0, 0, 0);
        io_lat = 16; io_rdata_val = 32'hA5A5_0001;
        issue(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 17, 32'hA5A5_0001, 1'b0, 0, 0, 16);
        io_lat = 1; io_rdata_val = 32'h0000_005A;
        issue(1'b1, 1'b1, 32'hFFFF_0000, 32'h1234_5678, 2, 32'h0, 1'b0, 0, 1, 0);
        issue(1'b1, 1'b1, 32'h1001_FFFF, 32'h0BAD_F00D, 2, 32'h0, 1'b0, 1, 0, 0);
        issue(1'b1, 1'b0, 32'h1001_FFFF, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 0, 0, 0);
        issue(1'b0, 1'b0, 32'h1000_FFFF, 32'h0, 1, 32'h0, 1'b1, 0, 0, 0);
        issue(1'b0, 1'b0, 32'h1002_0000, 32'h0, 1, 32'h0, 1'b1, 0, 0, 0);

        // Reset during an IO wait: the request is abandoned without an ack.
        io_lat = 0;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hFFFF_0100; m0_wdata = '0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_in_io", {31'd0, io_re}, 32'd1);
        rst = 1'b1;
        m0_req = 1'b0;
        @(posedge clk); #1;
        check("abort_strobes", {30'd0, io_we, io_re}, 32'd0);
        check("abort_ack", {31'd0, m0_ack}, 32'd0);
        rst = 1'b0;

        // Both masters held high after reset: m0, m1, m0 at t+2, t+5, t+8.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1001_0010; m0_wdata = 32'h1111_1111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1001_0020; m1_wdata = 32'h2222_2222;
        t = cyc;
        push_exp(1'b0, t + 2, 32'h1001_0010, 32'h1111_1111);
        push_exp(1'b1, t + 5, 32'h1001_0020, 32'h2222_2222);
        push_exp(1'b0, t + 8, 32'h1001_0010, 32'h1111_1111);
        n_ack = 0;
        for (int i = 0; i < 30 && n_ack < 3; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) n_ack++;
        end
        check("rr_acks_seen", 32'(n_ack), 32'd3);
        m0_req = 1'b0;
        m1_req = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
